global_buffer_model: RTL and testbench

- Behavioural model of the iCE40 global-buffer primitive: drives one user signal onto a low-skew global net.
- Used for clock and reset distribution, e.g. the 1x/2x divided clocks and the reset in the SerDes clock/reset generator.
- Adds an optional retiming stage and built-in activity instrumentation: rising-edge counter and stuck-signal detector.
- The instrumentation is clocked by the fast source clock, so benches and health logic can confirm that a buffered clock is toggling.

---
 rtl/global_buffer_model.sv | 48 ++++
 tb/tb_global_buffer_model.sv | 125 ++++++++++++
 2 files changed

// File: rtl/global_buffer_model.sv
// global_buffer_model: iCE40 global-buffer model with optional retiming,
// rising-edge counter and stuck-signal detector clocked by clk_4x.
module global_buffer_model #(
    parameter int REGISTERED  = 0,
    parameter int CNT_WIDTH   = 16,
    parameter int STUCK_LIMIT = 64
) (
    input  logic                 clk_4x,
    input  logic                 pll_lock,
    input  logic                 user_signal_to_global_buffer,
    output logic                 global_buffer_output,
    output logic [CNT_WIDTH-1:0] edge_cnt,
    output logic                 active
);
    localparam int IW = $clog2(STUCK_LIMIT + 1);
    localparam logic [IW-1:0] LIMIT = IW'(STUCK_LIMIT);

    logic          prev;
    logic          rise;
    logic          change;
    logic [IW-1:0] idle;
    logic [IW-1:0] idle_next;

    always_comb begin
        rise      = user_signal_to_global_buffer & ~prev;
        change    = user_signal_to_global_buffer ^ prev;
        idle_next = change ? '0 : (idle == LIMIT ? idle : idle + IW'(1));
    end

    // A change always wins over the idle counter reaching the limit.
    always_ff @(posedge clk_4x or negedge pll_lock) begin
        if (!pll_lock) begin
            prev     <= 1'b0;
            edge_cnt <= '0;
            idle     <= '0;
            active   <= 1'b0;
        end else begin
            prev   <= user_signal_to_global_buffer;
            idle   <= idle_next;
            active <= change | (active & (idle_next != LIMIT));
            if (rise && !(&edge_cnt))
                edge_cnt <= edge_cnt + CNT_WIDTH'(1);
        end
    end

    // The sample flop doubles as the retiming flop: same D, clock and reset.
    assign global_buffer_output = (REGISTERED != 0) ? prev : user_signal_to_global_buffer;
endmodule

// File: tb/tb_global_buffer_model.sv
// tb_global_buffer_model: directed checks of pass-through, retiming,
// edge counting/saturation, stuck detection and async reset.
module tb_global_buffer_model;
    logic        clk_4x = 1'b0;
    logic        pll_lock = 1'b0;
    logic        sig = 1'b0;
    logic        last;
    logic        o0, o1, o2;
    logic        a0, a1, a2;
    logic [15:0] e0, e1;
    logic [1:0]  e2;
    int          checks = 0;
    int          failures = 0;

    always #5 clk_4x = ~clk_4x;

    global_buffer_model #(.REGISTERED(0), .CNT_WIDTH(16), .STUCK_LIMIT(64)) u0 (
        .clk_4x(clk_4x), .pll_lock(pll_lock), .user_signal_to_global_buffer(sig),
        .global_buffer_output(o0), .edge_cnt(e0), .active(a0));
    global_buffer_model #(.REGISTERED(1), .CNT_WIDTH(16), .STUCK_LIMIT(8)) u1 (
        .clk_4x(clk_4x), .pll_lock(pll_lock), .user_signal_to_global_buffer(sig),
        .global_buffer_output(o1), .edge_cnt(e1), .active(a1));
    global_buffer_model #(.REGISTERED(0), .CNT_WIDTH(2), .STUCK_LIMIT(8)) u2 (
        .clk_4x(clk_4x), .pll_lock(pll_lock), .user_signal_to_global_buffer(sig),
        .global_buffer_output(o2), .edge_cnt(e2), .active(a2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset held: pass-through follows input, everything else cleared
        repeat (2) @(negedge clk_4x);
        for (int i = 0; i < 4; i++) begin
            sig = i[0];
            #1;
            check("rst_pass", 32'(o0), 32'(i[0]));
            check("rst_reg_zero", 32'(o1), 0);
            check("rst_cnt", 32'(e0), 0);
            check("rst_act", 32'(a0), 0);
            @(negedge clk_4x);
        end
        // Divider MSB pattern 0,0,1,1 on the retimed instance
        sig = 1'b0;
        pll_lock = 1'b1;
        last = 1'b0;
        for (int k = 0; k < 40; k++) begin
            check("retime_delay", 32'(o1), 32'(last));
            check("div_active", 32'(a0), 32'(k >= 3));
            sig = k[1];
            last = sig;
            @(negedge clk_4x);
        end
        check("retime_end", 32'(o1), 1);
        check("div_cnt10", 32'(e0), 10);
        check("div_sat2", 32'(e2), 3);
        // Square wave, CNT_WIDTH=2 saturates at 3
        pll_lock = 1'b0;
        #1;
        check("pulse_clr", 32'(e2), 0);
        @(negedge clk_4x);
        sig = 1'b0;
        pll_lock = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("sat_cnt", 32'(e2), 32'((k / 2) > 3 ? 3 : k / 2));
            check("wide_cnt", 32'(e0), 32'(k / 2));
            sig = k[0];
            @(negedge clk_4x);
        end
        check("wide_cnt_end", 32'(e0), 10);
        check("sat_end", 32'(e2), 3);
        // Hold constant: STUCK_LIMIT=8 drops on the 9th reading
        for (int h = 0; h < 9; h++) begin
            check("stuck8_u1", 32'(a1), 32'(h < 8));
            check("stuck8_u2", 32'(a2), 32'(h < 8));
            check("stuck64_u0", 32'(a0), 1);
            @(negedge clk_4x);
        end
        check("stuck8_held", 32'(a1), 0);
        sig = 1'b0;
        @(negedge clk_4x);
        check("stuck8_revive", 32'(a1), 1);
        // Build edge_cnt=5, then async reset pulse between edges
        pll_lock = 1'b0;
        @(negedge clk_4x);
        pll_lock = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sig = k[0];
            @(negedge clk_4x);
        end
        check("pre_pulse_cnt5", 32'(e0), 5);
        check("pre_pulse_out", 32'(o1), 1);
        #2 pll_lock = 1'b0;
        #1;
        check("async_cnt", 32'(e0), 0);
        check("async_act", 32'(a0), 0);
        check("async_out", 32'(o1), 0);
        check("async_sat", 32'(e2), 0);
        sig = 1'b1;
        #1;
        check("async_pass", 32'(o0), 1);
        repeat (3) @(negedge clk_4x);
        check("held_cnt", 32'(e0), 0);
        check("held_out", 32'(o1), 0);
        // Input high through release counts as one rising edge
        pll_lock = 1'b1;
        for (int h = 0; h < 10; h++) begin
            @(negedge clk_4x);
            check("release_cnt", 32'(e0), 1);
            check("release_act8", 32'(a1), 32'(h < 8));
            check("release_act64", 32'(a0), 1);
        end
        sig = 1'b0;
        @(negedge clk_4x);
        sig = 1'b1;
        @(negedge clk_4x);
        check("resume_cnt", 32'(e0), 2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
